// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and encodings for the EX-stage forwarding / hazard controller.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package fwd_hazard_ctrl_pkg;

    // Operand-select encodings driven onto forward_a / forward_b.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Register index field width carried in the stage struct. Narrower indices
    // are zero-extended into it, so REG_ADDR_W must not exceed this value.
    localparam int MAX_REG_ADDR_W = 8;

    // Per-stage control carried down the EX/MEM/WB pipeline.
    typedef struct packed {
        logic                      valid;
        logic                      regwrite;
        logic                      memread;
        logic [MAX_REG_ADDR_W-1:0] rd;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_BUBBLE = '0;

    // A stage produces a register result that others may depend on.
    // With a hardwired zero register, writes to r0 are architecturally dead.
    function automatic logic stage_writes(input stage_ctrl_t s, input bit zero_reg);
        return s.valid & s.regwrite & ~(zero_reg & (s.rd == '0));
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select.sv
// Forwarding select and operand mux for one EX-stage ALU source.
// Latency: purely combinational, select and operand settle in the same cycle.
// Backpressure: none; consumes whatever the pipeline presents.
module fwd_select
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              ex_valid,
    input  logic [ADDR_W-1:0] ex_src,
    input  logic              mem_fwd_ok,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              wb_fwd_ok,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] op
);

    // Pick the youngest producer of ex_src; only a live EX instruction forwards.
    always_comb begin
        sel = FWD_RF;
        if (ex_valid) begin
            if (mem_fwd_ok && (mem_rd == ex_src)) begin
                sel = FWD_MEM;
            end else if (wb_fwd_ok && (wb_rd == ex_src)) begin
                sel = FWD_WB;
            end
        end
    end

    // Steer the chosen source onto the ALU input; 11 never occurs and yields 0.
    always_comb begin
        op = '0;
        case (sel)
            FWD_RF:  op = rf_data;
            FWD_MEM: op = mem_data;
            FWD_WB:  op = wb_data;
            default: op = '0;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX/MEM/WB control pipeline, ALU operand forwarding, load-use stall and stall counter.
// Latency: ID fields reach EX one clock later; forwarding selects/operands are combinational.
// Backpressure: id_ready drops for exactly one cycle per load-use pair; a bubble enters EX.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter bit ZERO_REG   = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic                  id_ready,
    input  logic [DATA_W-1:0]     ex_rf_a,
    input  logic [DATA_W-1:0]     ex_rf_b,
    input  logic [DATA_W-1:0]     mem_alu_data,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [DATA_W-1:0]     alu_op_a,
    output logic [DATA_W-1:0]     alu_op_b,
    output logic                  ex_valid,
    output logic [CNT_W-1:0]      stall_count
);

    stage_ctrl_t               ex_q;
    stage_ctrl_t               mem_q;
    stage_ctrl_t               ex_d;
    logic [REG_ADDR_W-1:0]     ex_rs_q;
    logic [REG_ADDR_W-1:0]     ex_rt_q;
    // WB only needs to know whether it writes and where; memread is no longer relevant there.
    logic                      wb_wr_q;
    logic [MAX_REG_ADDR_W-1:0] wb_rd_q;

    logic                      ex_wr;
    logic                      mem_wr;
    logic                      mem_fwd_ok;
    logic                      load_use;
    logic                      ex_load;
    logic [MAX_REG_ADDR_W-1:0] id_rs_x;
    logic [MAX_REG_ADDR_W-1:0] id_rt_x;
    logic [MAX_REG_ADDR_W-1:0] ex_rs_x;
    logic [MAX_REG_ADDR_W-1:0] ex_rt_x;

    assign id_rs_x = MAX_REG_ADDR_W'(id_rs);
    assign id_rt_x = MAX_REG_ADDR_W'(id_rt);
    assign ex_rs_x = MAX_REG_ADDR_W'(ex_rs_q);
    assign ex_rt_x = MAX_REG_ADDR_W'(ex_rt_q);

    assign ex_wr  = stage_writes(ex_q, ZERO_REG);
    assign mem_wr = stage_writes(mem_q, ZERO_REG);

    // A load sitting in MEM has no data yet on mem_alu_data; its consumer was
    // stalled so that it picks the value up from WB instead.
    assign mem_fwd_ok = mem_wr & ~mem_q.memread;

    // Consumer in ID of a load currently in EX must wait one cycle.
    assign load_use = id_valid & ex_wr & ex_q.memread &
                      ((ex_q.rd == id_rs_x) | (ex_q.rd == id_rt_x));
    assign id_ready = ~load_use;

    // Flush dominates: a killed or stalled ID slot becomes a bubble.
    assign ex_load = id_valid & id_ready & ~flush;

    // Build the next EX control word from ID, or a bubble.
    always_comb begin
        ex_d = STAGE_BUBBLE;
        if (ex_load) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.rd       = MAX_REG_ADDR_W'(id_rd);
        end
    end

    // Pipeline advances every clock; reset discards all in-flight entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= STAGE_BUBBLE;
            mem_q   <= STAGE_BUBBLE;
            ex_rs_q <= '0;
            ex_rt_q <= '0;
            wb_wr_q <= 1'b0;
            wb_rd_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_wr_q <= mem_wr;
            wb_rd_q <= mem_q.rd;
            if (ex_load) begin
                ex_rs_q <= id_rs;
                ex_rt_q <= id_rt;
            end
        end
    end

    // Count load-use cycles (including flushed ones), holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (load_use && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign ex_valid = ex_q.valid;

    fwd_select #(
        .DATA_W (DATA_W),
        .ADDR_W (MAX_REG_ADDR_W)
    ) u_sel_a (
        .ex_valid   (ex_q.valid),
        .ex_src     (ex_rs_x),
        .mem_fwd_ok (mem_fwd_ok),
        .mem_rd     (mem_q.rd),
        .wb_fwd_ok  (wb_wr_q),
        .wb_rd      (wb_rd_q),
        .rf_data    (ex_rf_a),
        .mem_data   (mem_alu_data),
        .wb_data    (wb_data),
        .sel        (forward_a),
        .op         (alu_op_a)
    );

    fwd_select #(
        .DATA_W (DATA_W),
        .ADDR_W (MAX_REG_ADDR_W)
    ) u_sel_b (
        .ex_valid   (ex_q.valid),
        .ex_src     (ex_rt_x),
        .mem_fwd_ok (mem_fwd_ok),
        .mem_rd     (mem_q.rd),
        .wb_fwd_ok  (wb_wr_q),
        .wb_rd      (wb_rd_q),
        .rf_data    (ex_rf_b),
        .mem_data   (mem_alu_data),
        .wb_data    (wb_data),
        .sel        (forward_b),
        .op         (alu_op_b)
    );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with an expectation queue.
// Latency: expectations are checked one settle step after inputs are driven.
// Backpressure: the bench holds ID inputs itself while id_ready is low.
module tb_fwd_hazard_ctrl;

    localparam int DATA_W = 8;
    localparam int RA_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid, id_regwrite, id_memread, flush;
    logic [RA_W-1:0]   id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] ex_rf_a, ex_rf_b, mem_alu_data, wb_data;

    logic              id_ready, ex_valid;
    logic [1:0]        forward_a, forward_b;
    logic [DATA_W-1:0] alu_op_a, alu_op_b;
    logic [15:0]       stall_count;

    logic              s_id_ready, s_ex_valid;
    logic [1:0]        s_forward_a, s_forward_b;
    logic [DATA_W-1:0] s_alu_op_a, s_alu_op_b;
    logic [1:0]        s_stall_count;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ZERO_REG(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .id_ready(id_ready), .ex_rf_a(ex_rf_a), .ex_rf_b(ex_rf_b),
        .mem_alu_data(mem_alu_data), .wb_data(wb_data), .forward_a(forward_a),
        .forward_b(forward_b), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .ex_valid(ex_valid), .stall_count(stall_count)
    );

    fwd_hazard_ctrl #(.DATA_W(DATA_W), .REG_ADDR_W(RA_W), .ZERO_REG(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .id_ready(s_id_ready), .ex_rf_a(ex_rf_a), .ex_rf_b(ex_rf_b),
        .mem_alu_data(mem_alu_data), .wb_data(wb_data), .forward_a(s_forward_a),
        .forward_b(s_forward_b), .alu_op_a(s_alu_op_a), .alu_op_b(s_alu_op_b),
        .ex_valid(s_ex_valid), .stall_count(s_stall_count)
    );

    typedef enum int {K_FA, K_FB, K_OPA, K_OPB, K_EXV, K_RDY, K_CNT, K_SAT} kind_t;
    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] observe(kind_t k);
        case (k)
            K_FA:    return 32'(forward_a);
            K_FB:    return 32'(forward_b);
            K_OPA:   return 32'(alu_op_a);
            K_OPB:   return 32'(alu_op_b);
            K_EXV:   return 32'(ex_valid);
            K_RDY:   return 32'(id_ready);
            K_CNT:   return 32'(stall_count);
            K_SAT:   return 32'(s_stall_count);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                          input logic [RA_W-1:0] rd, input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0);
        flush        = 1'b0;
        ex_rf_a      = 8'd99;
        ex_rf_b      = 8'd77;
        mem_alu_data = 8'd0;
        wb_data      = 8'd0;

        // Reset state
        push("rst_exv", K_EXV, 0);
        push("rst_fa", K_FA, 2'b00);
        push("rst_fb", K_FB, 2'b00);
        push("rst_rdy", K_RDY, 1);
        push("rst_cnt", K_CNT, 0);
        drain();
        rst_n = 1'b1;

        // 1. EX/MEM forward
        set_id(1, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 1, 0, 0, 0, 0);
        push("t1_rdy", K_RDY, 1);
        drain();
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        mem_alu_data = 8'd20;
        push("t1_fa", K_FA, 2'b10);
        push("t1_opa", K_OPA, 20);
        push("t1_fb", K_FB, 2'b00);
        push("t1_opb", K_OPB, 77);
        push("t1_exv", K_EXV, 1);
        drain();

        // 2. MEM/WB forward
        set_id(1, 0, 0, 2, 1, 0);
        tick();
        set_id(1, 7, 7, 6, 1, 0);
        tick();
        set_id(1, 2, 0, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        wb_data = 8'd15;
        push("t2_fa", K_FA, 2'b01);
        push("t2_opa", K_OPA, 15);
        push("t2_fb", K_FB, 2'b00);
        drain();

        // 3. Priority, rs==rt both matching
        set_id(1, 0, 0, 3, 1, 0);
        tick();
        set_id(1, 0, 0, 3, 1, 0);
        tick();
        set_id(1, 3, 3, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        mem_alu_data = 8'd44;
        push("t3_fb", K_FB, 2'b10);
        push("t3_fa", K_FA, 2'b10);
        push("t3_opb", K_OPB, 44);
        push("t3_opa", K_OPA, 44);
        drain();

        // 4. Load-use
        set_id(1, 0, 0, 4, 1, 1);
        tick();
        set_id(1, 4, 0, 0, 0, 0);
        push("t4_rdy_lo", K_RDY, 0);
        push("t4_cnt0", K_CNT, 0);
        drain();
        tick();
        push("t4_bubble", K_EXV, 0);
        push("t4_bubble_fa", K_FA, 2'b00);
        push("t4_rdy_hi", K_RDY, 1);
        push("t4_cnt1", K_CNT, 1);
        drain();
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        wb_data = 8'd33;
        push("t4_fa", K_FA, 2'b01);
        push("t4_opa", K_OPA, 33);
        push("t4_exv", K_EXV, 1);
        drain();

        // 5. Zero register, flush, flush with load-use
        set_id(1, 0, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 0, 0, 0);
        push("t5_r0_rdy", K_RDY, 1);
        drain();
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        ex_rf_a = 8'd91;
        push("t5_r0_fa", K_FA, 2'b00);
        push("t5_r0_opa", K_OPA, 91);
        push("t5_r0_cnt", K_CNT, 1);
        drain();
        set_id(1, 0, 0, 5, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_id(1, 5, 0, 0, 0, 0);
        push("t5_flush_exv", K_EXV, 0);
        drain();
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        push("t5_noflushfwd_fa", K_FA, 2'b00);
        push("t5_after_exv", K_EXV, 1);
        drain();
        set_id(1, 0, 0, 6, 1, 1);
        tick();
        set_id(1, 6, 0, 0, 0, 0);
        flush = 1'b1;
        push("t5_fl_lu_rdy", K_RDY, 0);
        drain();
        tick();
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        push("t5_fl_lu_exv", K_EXV, 0);
        push("t5_fl_lu_cnt", K_CNT, 2);
        push("t5_fl_lu_sat", K_SAT, 2);
        drain();

        // 6. Reset mid-stream, then saturation
        set_id(1, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 1, 0, 0, 0, 0);
        tick();
        push("t6_pre_fa", K_FA, 2'b10);
        drain();
        rst_n = 1'b0;
        push("t6_rst_exv", K_EXV, 0);
        push("t6_rst_fa", K_FA, 2'b00);
        push("t6_rst_cnt", K_CNT, 0);
        push("t6_rst_sat", K_SAT, 0);
        push("t6_rst_rdy", K_RDY, 1);
        drain();
        rst_n = 1'b1;
        tick();
        push("t6_post_fa", K_FA, 2'b00);
        push("t6_post_exv", K_EXV, 1);
        drain();
        for (int i = 0; i < 4; i++) begin
            set_id(1, 0, 0, 2, 1, 1);
            tick();
            set_id(1, 2, 0, 0, 0, 0);
            tick();
            if (i == 1) begin
                push("t6_sat_mid", K_SAT, 2);
                drain();
            end
        end
        set_id(0, 0, 0, 0, 0, 0);
        push("t6_cnt4", K_CNT, 4);
        push("t6_sat3", K_SAT, 3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
